// File: rtl/proc_out_fifo.sv
// proc_out_fifo: output-side FIFO behind the processor's OUT port.
// Every (addr_out, io_out) word strobed by out_en is captured and replayed to
// a consumer over a valid/ready handshake. Words arriving while the FIFO is
// full and not being drained are dropped. A drop sets a sticky overflow flag
// and increments a saturating counter.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   io_out        processor output data
//   addr_out      processor output port address (carried through, not decoded)
//   out_en        processor output strobe, one word per high cycle
//   m_data/m_addr head-of-FIFO entry, read from storage at rd_ptr
//   m_valid       head entry valid (FIFO not empty)
//   m_ready       consumer accepts the head entry
//   count         number of stored words, 0..FDEPTH
//   full          count == FDEPTH
//   overflow      sticky, a word was dropped
//   ovf_clr       clears overflow and drop_cnt (a drop in the same cycle wins)
//   drop_cnt      saturating count of dropped words
module proc_out_fifo #(
    parameter int unsigned NUBITS = 16,
    parameter int unsigned NUIOOU = 2,
    parameter int unsigned FDEPTH = 8,
    parameter int unsigned NBDROP = 8,
    localparam int unsigned AW = (NUIOOU > 2) ? $clog2(NUIOOU) : 1,
    localparam int unsigned PW = $clog2(FDEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUBITS-1:0] io_out,
    input  logic [AW-1:0]     addr_out,
    input  logic              out_en,
    output logic [NUBITS-1:0] m_data,
    output logic [AW-1:0]     m_addr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic [NBDROP-1:0] drop_cnt
);

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [NUBITS-1:0] data;
    } entry_t;

    localparam logic [NBDROP-1:0] DROP_MAX = '1;

    entry_t        mem [FDEPTH];
    entry_t        wr_entry_c;
    entry_t        head_c;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt_c;
    logic          pop_c;
    logic          push_c;
    logic          drop_c;

    // Per-cycle events; a write into a full FIFO is accepted if the head leaves
    always_comb begin
        pop_c  = m_valid & m_ready;
        push_c = out_en & (~full | pop_c);
        drop_c = out_en & full & ~pop_c;
    end

    // Occupancy after this edge
    always_comb begin
        count_nxt_c = count;
        if (push_c && !pop_c) begin
            count_nxt_c = count + CW'(1);
        end else if (pop_c && !push_c) begin
            count_nxt_c = count - CW'(1);
        end
    end

    // Pointers, occupancy and the status flags derived from it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            m_valid <= 1'b0;
            full    <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count   <= count_nxt_c;
            m_valid <= (count_nxt_c != '0);
            full    <= (count_nxt_c == CW'(FDEPTH));
        end
    end

    // Sticky overflow and saturating drop counter; a drop beats a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop_c) begin
            overflow <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= NBDROP'(1);
            end else if (drop_cnt != DROP_MAX) begin
                drop_cnt <= drop_cnt + NBDROP'(1);
            end
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    always_comb begin
        wr_entry_c      = '0;
        wr_entry_c.addr = addr_out;
        wr_entry_c.data = io_out;
    end

    // Storage needs no reset; contents are only observed behind m_valid
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_entry_c;
        end
    end

    // Head entry straight from storage; depends on registered state only
    always_comb begin
        head_c = mem[rd_ptr];
        m_data = head_c.data;
        m_addr = head_c.addr;
    end

endmodule
